// File: rtl/ibex_mult_pext_seq_if.sv
// Request/response bundle between the EX stage and the Pext multiply sequencer.
// The EX stage drives the master side and the sequencer drives the slave side.
interface ibex_mult_pext_seq_if;
  logic        valid_i;
  logic        ready_o;
  logic        kill_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] acc_i;
  logic        signed_a_i;
  logic        signed_b_i;
  logic        crossed_i;
  logic [1:0]  cycle_count_i;
  logic        accum_sub_i;
  logic        res_hi_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic        busy_o;
  logic        ov_o;

  modport master (
    output valid_i, kill_i, op_a_i, op_b_i, acc_i, signed_a_i, signed_b_i,
           crossed_i, cycle_count_i, accum_sub_i, res_hi_i,
    input  ready_o, valid_o, result_o, busy_o, ov_o
  );

  modport slave (
    input  valid_i, kill_i, op_a_i, op_b_i, acc_i, signed_a_i, signed_b_i,
           crossed_i, cycle_count_i, accum_sub_i, res_hi_i,
    output ready_o, valid_o, result_o, busy_o, ov_o
  );
endinterface

// File: rtl/ibex_mult_pext_seq.sv
// Pext multi-cycle multiply sequencer: one 33x17 signed multiplier, 1-2 passes, optional accumulate.
// Define IBEX_PEXT_ACC_SAT_EN for signed saturating accumulate with ov_o; otherwise wrap and ov_o=0.
module ibex_mult_pext_seq #(
  parameter bit ResetAll = 1'b0
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_mult_pext_seq_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_ACC, S_DONE} state_e;

  state_e r_state, w_state_next;
  logic   w_accept;

  logic [1:0]         r_cc;
  logic               r_sub, r_hi, r_crossed, r_sb;
  logic signed [32:0] r_a;
  logic [31:0]        r_b, r_acc, r_word, r_result;
  logic signed [63:0] r_p0;

  logic [15:0]        w_half;
  logic signed [16:0] w_bh;
  logic signed [49:0] w_prod;
  logic signed [63:0] w_prod64, w_sum64;
  logic [31:0]        w_word, w_acc_res;

`ifdef IBEX_PEXT_ACC_SAT_EN
  logic r_ov, w_acc_ov;

  // Returns {saturated, value} for signed acc +/- word clamped to the 32-bit range.
  function automatic logic [32:0] sat_acc(input logic [31:0] acc, input logic [31:0] word,
                                          input logic sub);
    logic signed [32:0] s;
    s = sub ? ($signed({acc[31], acc}) - $signed({word[31], word}))
            : ($signed({acc[31], acc}) + $signed({word[31], word}));
    if (s[32] != s[31]) sat_acc = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    else                sat_acc = {1'b0, s[31:0]};
  endfunction

  assign {w_acc_ov, w_acc_res} = sat_acc(r_acc, r_word, r_sub);
  assign bus.ov_o = (r_state == S_DONE) && r_ov;
`else
  function automatic logic [31:0] wrap_acc(input logic [31:0] acc, input logic [31:0] word,
                                           input logic sub);
    wrap_acc = sub ? (acc - word) : (acc + word);
  endfunction

  assign w_acc_res = wrap_acc(r_acc, r_word, r_sub);
  assign bus.ov_o  = 1'b0;
`endif

  assign bus.ready_o  = ((r_state == S_IDLE) || (r_state == S_DONE)) && !bus.kill_i;
  assign w_accept     = bus.valid_i && bus.ready_o;
  assign bus.valid_o  = (r_state == S_DONE);
  assign bus.busy_o   = (r_state == S_P0) || (r_state == S_P1) || (r_state == S_ACC);
  assign bus.result_o = r_result;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_P0;
      S_P0:    w_state_next = r_cc[0] ? S_P1 : (r_cc[1] ? S_ACC : S_DONE);
      S_P1:    w_state_next = r_cc[1] ? S_ACC : S_DONE;
      S_ACC:   w_state_next = S_DONE;
      S_DONE:  w_state_next = w_accept ? S_P0 : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.kill_i) w_state_next = S_IDLE;
  end

  // Two-pass P0 uses the low half as an unsigned digit; the high half carries B's sign.
  always_comb begin
    w_half = ((r_state == S_P1) || (!r_cc[0] && r_crossed)) ? r_b[31:16] : r_b[15:0];
    w_bh   = (r_cc[0] && (r_state != S_P1)) ? {1'b0, w_half} : {r_sb & w_half[15], w_half};
  end

  assign w_prod   = 50'(r_a) * 50'(w_bh);
  assign w_prod64 = {{14{w_prod[49]}}, w_prod};
  assign w_sum64  = r_p0 + (w_prod64 << 16);

  always_comb begin
    if (r_state == S_P1) w_word = r_hi ? w_sum64[63:32] : w_sum64[31:0];
    else                 w_word = r_hi ? w_prod64[47:16] : w_prod64[31:0];
  end

  // Control state and the architecturally visible result are always reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_cc      <= '0;
      r_sub     <= 1'b0;
      r_hi      <= 1'b0;
      r_crossed <= 1'b0;
      r_sb      <= 1'b0;
`ifdef IBEX_PEXT_ACC_SAT_EN
      r_ov      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cc      <= bus.cycle_count_i;
        r_sub     <= bus.accum_sub_i;
        r_hi      <= bus.res_hi_i;
        r_crossed <= bus.crossed_i;
        r_sb      <= bus.signed_b_i;
      end
      if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
        r_result <= (r_state == S_ACC) ? w_acc_res : w_word;
`ifdef IBEX_PEXT_ACC_SAT_EN
        r_ov     <= (r_state == S_ACC) && w_acc_ov;
`endif
      end
    end
  end

  // Operand and partial-product registers; reset only when ResetAll is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (ResetAll) begin
        r_a    <= '0;
        r_b    <= '0;
        r_acc  <= '0;
        r_p0   <= '0;
        r_word <= '0;
      end
    end else begin
      if (w_accept) begin
        r_a   <= {bus.signed_a_i & bus.op_a_i[31], bus.op_a_i};
        r_b   <= bus.op_b_i;
        r_acc <= bus.acc_i;
      end
      if (r_state == S_P0) r_p0 <= w_prod64;
      if (((r_state == S_P0) || (r_state == S_P1)) && (w_state_next == S_ACC))
        r_word <= w_word;
    end
  end

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Randomized bench for ibex_mult_pext_seq against a full-width arithmetic reference model.
module tb_ibex_mult_pext_seq;

  typedef struct {
    logic [31:0] a, b, acc;
    logic        sa, sb, cr, sub, hi;
    logic [1:0]  cc;
  } op_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ibex_mult_pext_seq_if bus();

  ibex_mult_pext_seq #(.ResetAll(1'b0)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-operand product: the halves the hardware iterates over recombine to A*B exactly.
  function automatic logic [32:0] model(input op_t o);
    logic [63:0] ax, bx, p;
    logic [31:0] w;
    logic [15:0] h;
    int          ia, iw;
    longint      s;
    ax = o.sa ? {{32{o.a[31]}}, o.a} : {32'h0, o.a};
    if (o.cc[0]) begin
      bx = o.sb ? {{32{o.b[31]}}, o.b} : {32'h0, o.b};
      p  = ax * bx;
      w  = o.hi ? p[63:32] : p[31:0];
    end else begin
      h  = o.cr ? o.b[31:16] : o.b[15:0];
      bx = o.sb ? {{48{h[15]}}, h} : {48'h0, h};
      p  = ax * bx;
      w  = o.hi ? p[47:16] : p[31:0];
    end
    if (!o.cc[1]) return {1'b0, w};
    ia = o.acc;
    iw = w;
`ifdef IBEX_PEXT_ACC_SAT_EN
    s = o.sub ? (longint'(ia) - longint'(iw)) : (longint'(ia) + longint'(iw));
    if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
`else
    s = o.sub ? (longint'(ia) - longint'(iw)) : (longint'(ia) + longint'(iw));
    return {1'b0, s[31:0]};
`endif
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a   = pick32();
    o.b   = pick32();
    o.acc = pick32();
    o.sa  = 1'($urandom);
    o.sb  = 1'($urandom);
    o.cr  = 1'($urandom);
    o.sub = 1'($urandom);
    o.hi  = 1'($urandom);
    o.cc  = 2'($urandom);
    return o;
  endfunction

  function automatic op_t mk(input logic [1:0] cc, input logic sa, input logic sb,
                             input logic cr, input logic sub, input logic hi,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] acc);
    op_t o;
    o.cc = cc; o.sa = sa; o.sb = sb; o.cr = cr; o.sub = sub; o.hi = hi;
    o.a = a; o.b = b; o.acc = acc;
    return o;
  endfunction

  // Presents the op for one accepting edge, then scrambles the inputs.
  task automatic drive(input op_t o);
    bus.valid_i       = 1'b1;
    bus.op_a_i        = o.a;
    bus.op_b_i        = o.b;
    bus.acc_i         = o.acc;
    bus.signed_a_i    = o.sa;
    bus.signed_b_i    = o.sb;
    bus.crossed_i     = o.cr;
    bus.accum_sub_i   = o.sub;
    bus.res_hi_i      = o.hi;
    bus.cycle_count_i = o.cc;
    @(posedge clk_i);
    #1;
    bus.valid_i       = 1'b0;
    bus.op_a_i        = $urandom;
    bus.op_b_i        = $urandom;
    bus.acc_i         = $urandom;
    bus.signed_a_i    = 1'($urandom);
    bus.signed_b_i    = 1'($urandom);
    bus.crossed_i     = 1'($urandom);
    bus.accum_sub_i   = 1'($urandom);
    bus.res_hi_i      = 1'($urandom);
    bus.cycle_count_i = 2'($urandom);
  endtask

  // Returns at the falling edge of the DONE cycle.
  task automatic wait_result(input op_t o, input string tag);
    logic [32:0] exp;
    int          lat;
    exp = model(o);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk_i);
      if (bus.valid_o) lat = c;
    end
    check({tag, ":lat"}, 64'(lat), 64'(2 + int'(o.cc[0]) + int'(o.cc[1])));
    check({tag, ":res"}, 64'(bus.result_o), 64'(exp[31:0]));
    check({tag, ":ov"},  64'(bus.ov_o),     64'(exp[32]));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":valid"}, 64'(bus.valid_o), 64'd0);
    check({tag, ":busy"},  64'(bus.busy_o),  64'd0);
    check({tag, ":ready"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    op_t o, o2;
    bus.valid_i = 1'b0; bus.kill_i = 1'b0;
    bus.op_a_i = '0; bus.op_b_i = '0; bus.acc_i = '0;
    bus.signed_a_i = 1'b0; bus.signed_b_i = 1'b0; bus.crossed_i = 1'b0;
    bus.cycle_count_i = '0; bus.accum_sub_i = 1'b0; bus.res_hi_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    check("reset:result", 64'(bus.result_o), 64'd0);
    check("reset:ov",     64'(bus.ov_o),     64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    drive(mk(2'b00, 1, 1, 0, 0, 0, 32'hFFFF_FFFE, 32'h0003_0005, 32'h0));
    wait_result(mk(2'b00, 1, 1, 0, 0, 0, 32'hFFFF_FFFE, 32'h0003_0005, 32'h0), "cc00");
    @(negedge clk_i);
    o = mk(2'b01, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    drive(o); wait_result(o, "cc01_hi"); @(negedge clk_i);
    o = mk(2'b01, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    drive(o); wait_result(o, "cc01_lo"); @(negedge clk_i);
    o = mk(2'b01, 1, 1, 0, 0, 1, 32'h8000_0000, 32'h8000_0000, 32'h0);
    drive(o); wait_result(o, "cc01_smin");

    // Kill during DONE: the pulse for the finished op stays, nothing follows.
    bus.kill_i = 1'b1;
    #1;
    check("kill_done:valid", 64'(bus.valid_o), 64'd1);
    check("kill_done:ready", 64'(bus.ready_o), 64'd0);
    @(posedge clk_i); #1; bus.kill_i = 1'b0;
    @(negedge clk_i);
    check_idle("kill_done");

    o = mk(2'b11, 1, 1, 0, 0, 1, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF);
    drive(o); wait_result(o, "cc11_add"); @(negedge clk_i);
    o = mk(2'b10, 1, 1, 1, 1, 0, 32'd5, 32'h0007_0000, 32'd100);
    drive(o); wait_result(o, "cc10_sub"); @(negedge clk_i);

    // Kill in P1 of a two-pass op.
    drive(mk(2'b01, 1, 1, 0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0));
    @(negedge clk_i); @(negedge clk_i);
    check("kill_p1:busy", 64'(bus.busy_o), 64'd1);
    bus.kill_i = 1'b1;
    @(posedge clk_i); #1; bus.kill_i = 1'b0;
    @(negedge clk_i);
    check_idle("kill_p1");
    repeat (3) begin
      @(negedge clk_i);
      check("kill_p1:novalid", 64'(bus.valid_o), 64'd0);
    end
    o = rand_op();
    drive(o); wait_result(o, "after_kill"); @(negedge clk_i);

    // valid_i together with kill_i is not accepted.
    bus.valid_i = 1'b1; bus.kill_i = 1'b1;
    @(posedge clk_i); #1; bus.valid_i = 1'b0; bus.kill_i = 1'b0;
    @(negedge clk_i);
    check_idle("kill_valid");

    // Asynchronous reset pulse while in ACC.
    o = mk(2'b11, 0, 1, 0, 1, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h5555_5555);
    drive(o);
    repeat (3) @(negedge clk_i);
    check("rst_acc:busy", 64'(bus.busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_idle("rst_acc");
    check("rst_acc:result", 64'(bus.result_o), 64'd0);
    check("rst_acc:ov",     64'(bus.ov_o),     64'd0);
    #2; rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("rst_acc:novalid", 64'(bus.valid_o), 64'd0);
    end
    o = rand_op();
    drive(o); wait_result(o, "after_rst");

    // Back-to-back: second op accepted in the first op's DONE cycle.
    @(negedge clk_i);
    o  = mk(2'b11, 1, 0, 0, 1, 0, 32'h0000_0300, 32'h0000_0007, 32'h0000_1000);
    o2 = mk(2'b00, 0, 0, 1, 0, 1, 32'h0001_0001, 32'hFFFF_0000, 32'h0);
    drive(o); wait_result(o, "b2b_1");
    check("b2b:ready_in_done", 64'(bus.ready_o), 64'd1);
    drive(o2); wait_result(o2, "b2b_2");

    for (int i = 0; i < 300; i++) begin
      o = rand_op();
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk_i);
      check("rnd:ready", 64'(bus.ready_o), 64'd1);
      drive(o);
      wait_result(o, $sformatf("rnd%0d", i));
    end
    @(negedge clk_i);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ibex_mult_pext_seq.md
Name: ibex_mult_pext_seq

Overview:
- Multi-cycle multiply sequencer directly downstream of the Pext multiplier control decode.
- Consumes the decoded cycle count, crossed, sub and signedness controls, plus operands.
- Drives a single 33x17 signed multiplier over one or two passes, then an optional accumulate pass against rd.
- Returns one 32-bit result to the EX stage with a valid/ready handshake.

Parameters:
ResetAll, 1'b0, when 1 the internal operand/product registers are also reset (control state is always reset)

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
valid_i  input  1  new op request
ready_o  output  1  op can be accepted this cycle
kill_i  input  1  flush in-flight op
op_a_i  input  32  multiplicand A
op_b_i  input  32  multiplier B
acc_i  input  32  accumulator (rd) value, sampled at accept
signed_a_i  input  1  A signed
signed_b_i  input  1  B signed
crossed_i  input  1  single-pass mode: use B[31:16] instead of B[15:0]
cycle_count_i  input  2  bit0: two multiply passes; bit1: accumulate pass
accum_sub_i  input  1  accumulate pass subtracts (acc - word)
res_hi_i  input  1  select upper result word
valid_o  output  1  result valid (one-cycle pulse)
result_o  output  32  result
busy_o  output  1  op in flight (state not IDLE/DONE)
ov_o  output  1  accumulate saturated (only with macro; else tied 0)

Behaviour:
- FSM states: IDLE, P0, P1, ACC, DONE. Reset → IDLE; valid_o=0, result_o=0, busy_o=0, ov_o=0, ready_o=1.
- ready_o = (state==IDLE || state==DONE) && !kill_i.
- Accept: valid_i && ready_o. All inputs are registered at accept; later input changes are ignored.
- Transitions:
  - accept → P0.
  - P0 → P1 if cc[0], else ACC if cc[1], else DONE.
  - P1 → ACC if cc[1], else DONE.
  - ACC → DONE.
  - DONE → P0 on accept, else IDLE.
- Multiplier: Aext = 33-bit (sign-extended if signed_a, else zero-extended). Bh is a 17-bit extension of a 16-bit half.
- Two-pass mode (cc[0]=1):
  - P0: Bh = zero-ext B[15:0].
  - P1: Bh = B[31:16] extended per signed_b.
  - prod64 = p0 + (p1 << 16), 64-bit two's complement.
  - word = res_hi ? prod64[63:32] : prod64[31:0].
- Single-pass mode (cc[0]=0):
  - Bh = crossed ? B[31:16] : B[15:0], extended per signed_b.
  - prod sign-extended to 64 bits.
  - word = res_hi ? prod[47:16] : prod[31:0].
- crossed_i is ignored in two-pass mode.
- ACC: result = accum_sub ? acc - word : acc + word, 32-bit wrap.
- Without ACC, result = word.
- valid_o = 1 exactly in DONE. result_o is updated on entry to DONE and held until the next DONE.
- Latency accept→valid_o: 1 + cc[0] + cc[1] + 1 cycles (2..4).
- Throughput: back-to-back accept in DONE, no bubble.
- kill_i: any state → IDLE next cycle; no valid_o for the killed op. kill_i with valid_i in the same cycle: no accept. Kill while in DONE: valid_o is still high that cycle (result already produced).
- Async reset mid-op: immediate IDLE, no valid_o.
- busy_o = state ∈ {P0, P1, ACC}.

Optional Feature:
- Macro: IBEX_PEXT_ACC_SAT_EN.
- Defined: ACC treats acc and word as signed and saturates to 0x7FFFFFFF / 0x80000000. ov_o=1 in DONE when saturation occurred, else 0.
- Undefined: wrap arithmetic; ov_o tied 0; no saturation logic.

Test Plan:
- cc=00, signed both, crossed=0, res_hi=0, A=0xFFFFFFFE, B=0x00030005 → result 0xFFFFFFF6, valid_o 2 cycles after accept.
- cc=01, unsigned, A=B=0xFFFFFFFF: res_hi=1 → 0xFFFFFFFE; res_hi=0 → 0x00000001; signed A=B=0x80000000, res_hi=1 → 0x40000000; all valid_o 3 cycles after accept.
- cc=11, add, res_hi=1, A=B=0x00010000, acc=0x7FFFFFFF → 0x80000000, ov_o=0 without macro; 0x7FFFFFFF, ov_o=1 with macro; valid_o 4 cycles after accept.
- cc=10, accum_sub=1, crossed=1, A=5, B=0x00070000, acc=100 → 65 (0x41).
- kill_i asserted in P1 of a cc=01 op → no valid_o, ready_o=1 next cycle; following op accepted and correct. Repeat with rst_ni pulse in ACC → outputs at reset values.
- Two ops back-to-back, second accepted in first op's DONE → two valid_o pulses, correct independent results, no idle cycle between.
